// File: rtl/hazard_stall_if.sv
// hazard_stall_if: decode/main-control side signals of the hazard stall unit
interface hazard_stall_if #(parameter int REG_ADDR_W = 3);
  logic                  instr_valid;
  logic [REG_ADDR_W-1:0] src_a_addr;
  logic [REG_ADDR_W-1:0] src_b_addr;
  logic [REG_ADDR_W-1:0] dst_addr;
  logic                  memRd_flg;
  logic                  reg_write_flg;
  logic                  jmp_flg;
  logic                  brnch_flg;
  logic                  stall_flg;
  logic                  pc_hold;
  logic                  ifid_hold;
  logic                  flush_flg;
  modport master (
    output instr_valid, src_a_addr, src_b_addr, dst_addr, memRd_flg, reg_write_flg, jmp_flg, brnch_flg,
    input  stall_flg, pc_hold, ifid_hold, flush_flg
  );
  modport slave (
    input  instr_valid, src_a_addr, src_b_addr, dst_addr, memRd_flg, reg_write_flg, jmp_flg, brnch_flg,
    output stall_flg, pc_hold, ifid_hold, flush_flg
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use stall and post-jump flush sequencer; HAZARD_PERF_EN adds saturating stall/flush counters
module hazard_stall_unit #(
  parameter int REG_ADDR_W   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int CTRL_PENALTY = 2,
  parameter int R0_HARDWIRED = 1
) (
  input logic clk,
  input logic rst,
  hazard_stall_if.slave bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] ld_stall_count,
  output logic [15:0] flush_count
`endif
);
  typedef enum logic [1:0] {RUN, LD_STALL, FLUSH} state_t;
  state_t                st;
  logic [2:0]            cnt;
  logic                  ld_pend;
  logic [REG_ADDR_W-1:0] ld_dst;
  logic                  haz;
  assign haz = ld_pend & bus.instr_valid
             & (bus.src_a_addr == ld_dst | bus.src_b_addr == ld_dst)
             & !(R0_HARDWIRED != 0 && ld_dst == '0);
  // Outputs depend only on state and the registered load tracker, never on the gated control flags
  assign bus.stall_flg = st == RUN ? haz : 1'b1;
  assign bus.pc_hold   = st == RUN ? haz : st == LD_STALL;
  assign bus.ifid_hold = st == RUN ? haz : st == LD_STALL;
  assign bus.flush_flg = st == FLUSH;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= RUN;
      cnt     <= '0;
      ld_pend <= 1'b0;
      ld_dst  <= '0;
    end else begin
      ld_pend <= bus.instr_valid & bus.memRd_flg & bus.reg_write_flg & ~bus.stall_flg;
      ld_dst  <= bus.dst_addr;
      case (st)
        RUN: begin
          if (haz && LOAD_LAT > 1) begin
            st  <= LD_STALL;
            cnt <= 3'(LOAD_LAT - 1);
          end else if (!haz && bus.instr_valid && (bus.jmp_flg || bus.brnch_flg) && CTRL_PENALTY > 0) begin
            st  <= FLUSH;
            cnt <= 3'(CTRL_PENALTY);
          end
        end
        default: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) st <= RUN;
        end
      endcase
    end
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_stall_count <= '0;
      flush_count    <= '0;
    end else begin
      if (bus.stall_flg && !bus.flush_flg && ld_stall_count != 16'hFFFF) ld_stall_count <= ld_stall_count + 16'd1;
      if (bus.flush_flg && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: three DUT configurations share directed stimulus; a queue-fed monitor checks outputs each cycle
module tb_hazard_stall_unit;
  localparam int LAT [3] = '{1, 3, 2};
  localparam int CP  [3] = '{2, 0, 2};
  localparam logic [3:0] idl = 4'b0000;
  localparam logic [3:0] stl = 4'b1110;
  localparam logic [3:0] fls = 4'b1001;
  typedef struct {int idx; logic [11:0] exp;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v = 1'b0, mr = 1'b0, rw = 1'b0, jp = 1'b0, br = 1'b0;
  logic [2:0] src_a = '0, src_b = '0, dst = '0;
  logic [11:0] got;
  logic [15:0] lsc [3];
  logic [15:0] fc [3];
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int step_no = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : d
    hazard_stall_if #(.REG_ADDR_W(3)) bus ();
    // Model main control: every flag it issues is squashed while the unit stalls
    assign bus.instr_valid   = v;
    assign bus.src_a_addr    = src_a;
    assign bus.src_b_addr    = src_b;
    assign bus.dst_addr      = dst;
    assign bus.memRd_flg     = mr & ~bus.stall_flg;
    assign bus.reg_write_flg = rw & ~bus.stall_flg;
    assign bus.jmp_flg       = jp & ~bus.stall_flg;
    assign bus.brnch_flg     = br & ~bus.stall_flg;
    assign got[4*g +: 4]     = {bus.stall_flg, bus.pc_hold, bus.ifid_hold, bus.flush_flg};
    hazard_stall_unit #(.REG_ADDR_W(3), .LOAD_LAT(LAT[g]), .CTRL_PENALTY(CP[g]), .R0_HARDWIRED(1)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef HAZARD_PERF_EN
      ,
      .ld_stall_count(lsc[g]),
      .flush_count(fc[g])
`endif
    );
  end
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (got !== e.exp) begin
        n_bad++;
        $display("FAIL step%0d outputs {c,b,a}: got %h expected %h", e.idx, got, e.exp);
      end
    end
  end
  task automatic step(input logic r, input logic vv, input logic [2:0] a, input logic [2:0] b, input logic [2:0] dd,
                      input logic m, input logic w, input logic j, input logic bb,
                      input logic [3:0] ec, input logic [3:0] eb, input logic [3:0] ea);
    exp_t e;
    rst = r; v = vv; src_a = a; src_b = b; dst = dd; mr = m; rw = w; jp = j; br = bb;
    e.idx = step_no;
    e.exp = {ec, eb, ea};
    q.push_back(e);
    step_no++;
    @(posedge clk);
    #1;
  endtask
  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  initial begin
    @(posedge clk);
    #1;
    step(1, 1, 3'd1, 3'd2, 3'd4, 0, 0, 0, 0, idl, idl, idl);
    for (int i = 0; i < 20; i++) step(0, 1, 3'd1, 3'd2, 3'd4, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd3, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd3, 3'd6, 3'd7, 0, 0, 0, 0, stl, stl, stl);
    step(0, 1, 3'd3, 3'd6, 3'd7, 0, 0, 0, 0, stl, stl, idl);
    step(0, 1, 3'd3, 3'd6, 3'd7, 0, 0, 0, 0, idl, stl, idl);
    step(0, 1, 3'd3, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd0, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd0, 3'd0, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd2, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd2, 3'd7, 0, 0, 0, 0, stl, stl, stl);
    step(0, 1, 3'd5, 3'd2, 3'd7, 0, 0, 0, 0, stl, stl, idl);
    step(0, 1, 3'd5, 3'd2, 3'd7, 0, 0, 0, 0, idl, stl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 1, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, fls, idl, fls);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, fls, idl, fls);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 0, 3'd5, 3'd6, 3'd7, 0, 0, 0, 1, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd4, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 1, 0, stl, stl, stl);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 1, 0, stl, stl, idl);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 1, 0, idl, stl, fls);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 1, 0, fls, idl, fls);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 0, 0, fls, idl, idl);
    step(0, 1, 3'd4, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd1, 3'd2, 3'd5, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, stl, stl, stl);
    step(1, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd5, 3'd6, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    step(0, 1, 3'd1, 3'd2, 3'd6, 1, 1, 0, 0, idl, idl, idl);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 0, stl, stl, stl);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 0, stl, stl, idl);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 1, idl, stl, idl);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 0, fls, idl, fls);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 0, fls, idl, fls);
    step(0, 1, 3'd6, 3'd2, 3'd7, 0, 0, 0, 0, idl, idl, idl);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
    end
`ifdef HAZARD_PERF_EN
    chk16("ld_stall_count_a", lsc[0], 16'd1);
    chk16("ld_stall_count_b", lsc[1], 16'd3);
    chk16("ld_stall_count_c", lsc[2], 16'd2);
    chk16("flush_count_a", fc[0], 16'd2);
    chk16("flush_count_b", fc[1], 16'd0);
    chk16("flush_count_c", fc[2], 16'd2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
